// File: rtl/mext_dispatch.sv
// RV32M dispatch: decodes funct3, launches the multiplier or divider, resolves divide special
// cases locally and returns the result with a one-cycle ready pulse. Optional: MEXT_RESULT_CACHE_EN.

`ifndef MUL_OP_WIDTH
`define MUL_OP_WIDTH 2
`define MUL_OP_MUL   2'd0
`define MUL_OP_MULH  2'd1
`define MUL_OP_MULSU 2'd2
`define MUL_OP_MULU  2'd3
`endif

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV   2'd0
`define DIV_OP_DIVU  2'd1
`define DIV_OP_REM   2'd2
`define DIV_OP_REMU  2'd3
`endif

module mext_dispatch (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [2:0]               funct3,
    input  logic [31:0]              rs1,
    input  logic [31:0]              rs2,
    output logic                     ready,
    output logic [31:0]              rd,
    output logic                     mul_valid,
    output logic [`MUL_OP_WIDTH-1:0] MULop,
    output logic [31:0]              mul_a,
    output logic [31:0]              mul_b,
    input  logic                     mul_ready,
    input  logic [31:0]              mul_result,
    output logic                     div_valid,
    output logic [`DIV_OP_WIDTH-1:0] DIVop,
    output logic [31:0]              div_a,
    output logic [31:0]              div_b,
    input  logic                     div_ready,
    input  logic [31:0]              div_result
);

    typedef enum logic [3:0] {
        StIdle    = 4'b0001,
        StMulWait = 4'b0010,
        StDivWait = 4'b0100,
        StDone    = 4'b1000
    } state_e;

    state_e                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic [31:0]              rd_q, rd_d;
    logic                     mul_valid_q, mul_valid_d;
    logic                     div_valid_q, div_valid_d;
    logic [`MUL_OP_WIDTH-1:0] mulop_q, mulop_d;
    logic [`DIV_OP_WIDTH-1:0] divop_q, divop_d;
    logic [31:0]              opa_q, opa_d;
    logic [31:0]              opb_q, opb_d;

    logic div_by_zero;
    logic div_ovf;
    logic cache_hit;

    function automatic logic [`MUL_OP_WIDTH-1:0] mul_decode(input logic [1:0] f);
        case (f)
            2'b00:   return `MUL_OP_MUL;
            2'b01:   return `MUL_OP_MULH;
            2'b10:   return `MUL_OP_MULSU;
            default: return `MUL_OP_MULU;
        endcase
    endfunction

    function automatic logic [`DIV_OP_WIDTH-1:0] div_decode(input logic [1:0] f);
        case (f)
            2'b00:   return `DIV_OP_DIV;
            2'b01:   return `DIV_OP_DIVU;
            2'b10:   return `DIV_OP_REM;
            default: return `DIV_OP_REMU;
        endcase
    endfunction

    // funct3[1] selects remainder, funct3[0] selects unsigned; overflow exists only when signed
    assign div_by_zero = (rs2 == 32'h0000_0000);
    assign div_ovf     = !funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

`ifdef MEXT_RESULT_CACHE_EN
    logic [2:0]  f3_q, f3_d;
    logic        cache_vld_q, cache_vld_d;
    logic [2:0]  cache_f3_q, cache_f3_d;
    logic [31:0] cache_a_q, cache_a_d;
    logic [31:0] cache_b_q, cache_b_d;
    logic [31:0] cache_rd_q, cache_rd_d;

    assign cache_hit = cache_vld_q && (cache_f3_q == funct3) && (cache_a_q == rs1)
                       && (cache_b_q == rs2);
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        rd_d        = rd_q;
        mul_valid_d = mul_valid_q;
        div_valid_d = div_valid_q;
        mulop_d     = mulop_q;
        divop_d     = divop_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
`ifdef MEXT_RESULT_CACHE_EN
        f3_d        = f3_q;
        cache_vld_d = cache_vld_q;
        cache_f3_d  = cache_f3_q;
        cache_a_d   = cache_a_q;
        cache_b_d   = cache_b_q;
        cache_rd_d  = cache_rd_q;
`endif

        unique case (state_q)
            StIdle: begin
                // ready_q high means this is the completion cycle of the previous op
                if (valid && !ready_q) begin
                    opa_d   = rs1;
                    opb_d   = rs2;
                    mulop_d = mul_decode(funct3[1:0]);
                    divop_d = div_decode(funct3[1:0]);
`ifdef MEXT_RESULT_CACHE_EN
                    f3_d    = funct3;
                    rd_d    = cache_rd_q;
`endif
                    if (cache_hit) begin
                        state_d = StDone;
                    end else if (!funct3[2]) begin
                        mul_valid_d = 1'b1;
                        state_d     = StMulWait;
                    end else if (div_by_zero) begin
                        rd_d    = funct3[1] ? rs1 : 32'hFFFF_FFFF;
                        state_d = StDone;
                    end else if (div_ovf) begin
                        rd_d    = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
                        state_d = StDone;
                    end else begin
                        div_valid_d = 1'b1;
                        state_d     = StDivWait;
                    end
                end
            end
            StMulWait: begin
                if (mul_ready) begin
                    rd_d        = mul_result;
                    mul_valid_d = 1'b0;
                    state_d     = StDone;
                end
            end
            StDivWait: begin
                if (div_ready) begin
                    rd_d        = div_result;
                    div_valid_d = 1'b0;
                    state_d     = StDone;
                end
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
`ifdef MEXT_RESULT_CACHE_EN
                cache_vld_d = 1'b1;
                cache_f3_d  = f3_q;
                cache_a_d   = opa_q;
                cache_b_d   = opb_q;
                cache_rd_d  = rd_q;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            rd_q        <= 32'h0000_0000;
            mul_valid_q <= 1'b0;
            div_valid_q <= 1'b0;
            mulop_q     <= '0;
            divop_q     <= '0;
            opa_q       <= 32'h0000_0000;
            opb_q       <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rd_q        <= rd_d;
            mul_valid_q <= mul_valid_d;
            div_valid_q <= div_valid_d;
            mulop_q     <= mulop_d;
            divop_q     <= divop_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
        end
    end

`ifdef MEXT_RESULT_CACHE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q        <= 3'b000;
            cache_vld_q <= 1'b0;
            cache_f3_q  <= 3'b000;
            cache_a_q   <= 32'h0000_0000;
            cache_b_q   <= 32'h0000_0000;
            cache_rd_q  <= 32'h0000_0000;
        end else begin
            f3_q        <= f3_d;
            cache_vld_q <= cache_vld_d;
            cache_f3_q  <= cache_f3_d;
            cache_a_q   <= cache_a_d;
            cache_b_q   <= cache_b_d;
            cache_rd_q  <= cache_rd_d;
        end
    end
`endif

    // Both units share the latched operands; only the launched unit's valid is raised
    assign ready     = ready_q;
    assign rd        = rd_q;
    assign mul_valid = mul_valid_q;
    assign MULop     = mulop_q;
    assign mul_a     = opa_q;
    assign mul_b     = opb_q;
    assign div_valid = div_valid_q;
    assign DIVop     = divop_q;
    assign div_a     = opa_q;
    assign div_b     = opb_q;

endmodule

// File: tb/tb_mext_dispatch.sv
// Self-checking bench for mext_dispatch: stub mul/div units with programmable latency, a
// transaction-level result/latency model, and a per-cycle compare process.

`timescale 1ns/1ps

`ifndef MUL_OP_WIDTH
`define MUL_OP_WIDTH 2
`define MUL_OP_MUL   2'd0
`define MUL_OP_MULH  2'd1
`define MUL_OP_MULSU 2'd2
`define MUL_OP_MULU  2'd3
`endif

`ifndef DIV_OP_WIDTH
`define DIV_OP_WIDTH 2
`define DIV_OP_DIV   2'd0
`define DIV_OP_DIVU  2'd1
`define DIV_OP_REM   2'd2
`define DIV_OP_REMU  2'd3
`endif

module tb_mext_dispatch;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     valid = 1'b0;
    logic [2:0]               funct3 = 3'b000;
    logic [31:0]              rs1 = 32'h0;
    logic [31:0]              rs2 = 32'h0;
    logic                     ready;
    logic [31:0]              rd;
    logic                     mul_valid;
    logic [`MUL_OP_WIDTH-1:0] MULop;
    logic [31:0]              mul_a, mul_b;
    logic                     mul_ready = 1'b0;
    logic [31:0]              mul_result = 32'h0;
    logic                     div_valid;
    logic [`DIV_OP_WIDTH-1:0] DIVop;
    logic [31:0]              div_a, div_b;
    logic                     div_ready = 1'b0;
    logic [31:0]              div_result = 32'h0;

    mext_dispatch dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .ready      (ready),
        .rd         (rd),
        .mul_valid  (mul_valid),
        .MULop      (MULop),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ready  (mul_ready),
        .mul_result (mul_result),
        .div_valid  (div_valid),
        .DIVop      (DIVop),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Expectations of the op in flight
    int                       exp_ready_cyc = -1;
    int                       exp_unit = 0;       // 0 none, 1 multiplier, 2 divider
    logic [31:0]              exp_rd = 32'h0;
    logic [31:0]              exp_a = 32'h0;
    logic [31:0]              exp_b = 32'h0;
    logic [`MUL_OP_WIDTH-1:0] exp_mulop = '0;
    logic [`DIV_OP_WIDTH-1:0] exp_divop = '0;
    bit                       launch_seen = 1'b0;

    int mul_lat = 3;
    int div_lat = 5;
    int spur_mul_cyc = -1;
    int spur_div_cyc = -1;

    // Model of the last-result cache
    bit          c_vld = 1'b0;
    logic [2:0]  c_f3 = 3'b000;
    logic [31:0] c_a = 32'h0, c_b = 32'h0, c_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RV32M result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_rd(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, sub;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sub = longint'({32'd0, b});
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (f3)
            3'b000: begin p = sa * sb;  return p[31:0];  end
            3'b001: begin p = sa * sb;  return p[63:32]; end
            3'b010: begin p = sa * sub; return p[63:32]; end
            3'b011: begin p = ua * ub;  return p[63:32]; end
            3'b100: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'h0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [`MUL_OP_WIDTH-1:0] f3_mulop(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return `MUL_OP_MUL;
            2'b01:   return `MUL_OP_MULH;
            2'b10:   return `MUL_OP_MULSU;
            default: return `MUL_OP_MULU;
        endcase
    endfunction

    function automatic logic [`DIV_OP_WIDTH-1:0] f3_divop(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return `DIV_OP_DIV;
            2'b01:   return `DIV_OP_DIVU;
            2'b10:   return `DIV_OP_REM;
            default: return `DIV_OP_REMU;
        endcase
    endfunction

    function automatic logic [31:0] mul_unit(input logic [`MUL_OP_WIDTH-1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        case (op)
            `MUL_OP_MUL:   return ref_rd(3'b000, a, b);
            `MUL_OP_MULH:  return ref_rd(3'b001, a, b);
            `MUL_OP_MULSU: return ref_rd(3'b010, a, b);
            default:       return ref_rd(3'b011, a, b);
        endcase
    endfunction

    function automatic logic [31:0] div_unit(input logic [`DIV_OP_WIDTH-1:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        case (op)
            `DIV_OP_DIV:  return ref_rd(3'b100, a, b);
            `DIV_OP_DIVU: return ref_rd(3'b101, a, b);
            `DIV_OP_REM:  return ref_rd(3'b110, a, b);
            default:      return ref_rd(3'b111, a, b);
        endcase
    endfunction

    // Stub units: ready pulses lat cycles after the launch edge; result computed from operands
    // as seen on the final cycle. Spurious pulses carry a poison result.
    int mcnt = 0, dcnt = 0;
    bit mbusy = 1'b0, dbusy = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            mbusy = 1'b0; dbusy = 1'b0;
            mul_ready = 1'b0; div_ready = 1'b0;
        end else begin
            if (mbusy) begin
                if (mcnt == 0) mbusy = 1'b0;
                else mcnt--;
            end
            if (dbusy) begin
                if (dcnt == 0) dbusy = 1'b0;
                else dcnt--;
            end
            if (!mbusy && mul_valid) begin mbusy = 1'b1; mcnt = mul_lat - 1; end
            if (!dbusy && div_valid) begin dbusy = 1'b1; dcnt = div_lat - 1; end
            mul_ready = 1'b0; mul_result = 32'h0;
            div_ready = 1'b0; div_result = 32'h0;
            if (mbusy && mcnt == 0) begin
                mul_ready = 1'b1; mul_result = mul_unit(MULop, mul_a, mul_b);
            end else if (cyc == spur_mul_cyc) begin
                mul_ready = 1'b1; mul_result = 32'hDEAD_BEEF;
            end
            if (dbusy && dcnt == 0) begin
                div_ready = 1'b1; div_result = div_unit(DIVop, div_a, div_b);
            end else if (cyc == spur_div_cyc) begin
                div_ready = 1'b1; div_result = 32'hDEAD_BEEF;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_timing", 32'(ready), 32'(cyc == exp_ready_cyc));
            if (ready) begin
                chk("rd_on_ready", rd, exp_rd);
                chk("mul_valid_at_done", 32'(mul_valid), 32'h0);
                chk("div_valid_at_done", 32'(div_valid), 32'h0);
            end
            if (mul_valid) launch_seen = 1'b1;
            if (div_valid) launch_seen = 1'b1;
            if (exp_unit != 1) chk("unexpected_mul_valid", 32'(mul_valid), 32'h0);
            else if (mul_valid) begin
                chk("MULop_held", 32'(MULop), 32'(exp_mulop));
                chk("mul_a_held", mul_a, exp_a);
                chk("mul_b_held", mul_b, exp_b);
            end
            if (exp_unit != 2) chk("unexpected_div_valid", 32'(div_valid), 32'h0);
            else if (div_valid) begin
                chk("DIVop_held", 32'(DIVop), 32'(exp_divop));
                chk("div_a_held", div_a, exp_a);
                chk("div_b_held", div_b, exp_b);
            end
        end
    end

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit use_lit, input logic [31:0] lit,
                         input bit drop, input int smul, input int sdiv);
        int n, lat;
        bit special, hit, got;
        @(negedge clk);
        n = cyc;
        special = f3[2] && ((b == 32'h0) ||
                  (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        hit = 1'b0;
`ifdef MEXT_RESULT_CACHE_EN
        hit = c_vld && (c_f3 == f3) && (c_a == a) && (c_b == b);
`endif
        if (hit || special) begin lat = 2; exp_unit = 0; end
        else if (!f3[2])    begin lat = mul_lat + 2; exp_unit = 1; end
        else                begin lat = div_lat + 2; exp_unit = 2; end
        exp_rd        = ref_rd(f3, a, b);
        exp_ready_cyc = n + lat;
        exp_mulop     = f3_mulop(f3);
        exp_divop     = f3_divop(f3);
        exp_a         = a;
        exp_b         = b;
        launch_seen   = 1'b0;
        spur_mul_cyc  = (smul > 0) ? n + smul : -1;
        spur_div_cyc  = (sdiv > 0) ? n + sdiv : -1;
        funct3 = f3; rs1 = a; rs2 = b; valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (drop) begin
                valid = 1'b0; funct3 = ~f3; rs1 = ~a; rs2 = a;
            end
            if (ready) got = 1'b1;
        end
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: ready got 0, want 1 within 100 cycles", name);
        end else begin
            chk({name, "_latency"}, 32'(cyc - n), 32'(lat));
            chk({name, "_launch"}, 32'(launch_seen), 32'(exp_unit != 0));
            if (use_lit) chk({name, "_rd"}, rd, lit);
        end
        c_vld = 1'b1; c_f3 = f3; c_a = a; c_b = b; c_rd = exp_rd;
        @(negedge clk);
        valid = 1'b0;
        spur_mul_cyc = -1;
        spur_div_cyc = -1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_mul_valid", 32'(mul_valid), 32'h0);
        chk("rst_div_valid", 32'(div_valid), 32'h0);
        chk("rst_MULop", 32'(MULop), 32'h0);
        chk("rst_DIVop", 32'(DIVop), 32'h0);
        chk("rst_mul_a", mul_a, 32'h0);
        chk("rst_div_b", div_b, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        mul_lat = 3; div_lat = 5;
        do_op("mul_7x6",      3'b000, 32'd7,        32'd6,        1, 32'd42,       0, 0, 0);
        do_op("mulh_m1m1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, 0, 0, 0);
        do_op("mulhu_m1m1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 0, 0, 0);
        do_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF, 32'd2,        1, 32'hFFFFFFFF, 0, 0, 0);
        do_op("divu_by0",     3'b101, 32'd100,      32'd0,        1, 32'hFFFFFFFF, 0, 0, 0);
        do_op("remu_by0",     3'b111, 32'd100,      32'd0,        1, 32'd100,      0, 0, 0);
        do_op("div_by0",      3'b100, 32'd100,      32'd0,        1, 32'hFFFFFFFF, 0, 0, 0);
        do_op("rem_by0",      3'b110, 32'hFFFFFFF9, 32'd0,        1, 32'hFFFFFFF9, 0, 0, 0);
        do_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0, 0, 0);
        do_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 0, 0, 0);
        do_op("divu_noovf",   3'b101, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 0, 0, 0);
        do_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        1, 32'hFFFFFFFF, 0, 0, 0);
        do_op("div_m100_7",   3'b100, 32'hFFFFFF9C, 32'd7,        1, 32'hFFFFFFF2, 0, 0, 0);

        mul_lat = 5;
        do_op("mul_spur_div", 3'b000, 32'h00012345, 32'h10,       1, 32'h00123450, 0, 0, 2);
        do_op("mul_both_rdy", 3'b000, 32'd3,        32'd5,        1, 32'd15,       0, 0, 5);
        do_op("div_spur_mul", 3'b100, 32'd50,       32'hFFFFFFFB, 1, 32'hFFFFFFF6, 0, 3, 0);
        mul_lat = 3;
        do_op("mulhu_drop",   3'b011, 32'h12345678, 32'h9ABCDEF0, 1, 32'h0B00EA4E, 1, 0, 0);
        do_op("mulhu_again",  3'b011, 32'h12345678, 32'h9ABCDEF0, 1, 32'h0B00EA4E, 0, 0, 0);
        do_op("mulhu_new_b",  3'b011, 32'h12345678, 32'h9ABCDEF1, 0, 32'h0,        0, 0, 0);

        // Reset in the middle of a divide
        @(negedge clk);
        exp_unit = 2;
        exp_a = 32'hFFFFFFF9; exp_b = 32'd2; exp_divop = f3_divop(3'b110);
        exp_ready_cyc = cyc + div_lat + 2;
        funct3 = 3'b110; rs1 = 32'hFFFFFFF9; rs2 = 32'd2; valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("div_valid_before_reset", 32'(div_valid), 32'h1);
        reset = 1'b1;
        valid = 1'b0;
        #1;
        exp_unit = 0;
        exp_ready_cyc = -1;
        c_vld = 1'b0;
        chk("midrst_ready", 32'(ready), 32'h0);
        chk("midrst_div_valid", 32'(div_valid), 32'h0);
        chk("midrst_mul_valid", 32'(mul_valid), 32'h0);
        chk("midrst_rd", rd, 32'h0);
        chk("midrst_DIVop", 32'(DIVop), 32'h0);
        chk("midrst_div_a", div_a, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_op("mul_after_rst", 3'b000, 32'd7, 32'd6, 1, 32'd42, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
